control_unit: RTL
=================

Name: control_unit

Overview:
- Multicycle sequencer for the Redux-V 8-bit core. It sits directly upstream of reg_bank.
- Fetches an 8-bit instruction, decodes it, and drives the reg_bank read/write ports (r_a, r_b, write_addr, write_enable, write_data).
- Steers the ALU and data memory, and owns the PC.
- reg_bank outputs a/b feed back as reg_a/reg_b for branches, ALU operands and memory address/data.

Parameters:
RESET_PC, 8'h00, PC value loaded on reset.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
instr  in  8  instruction memory data at address pc (combinational ROM)
pc  out  8  program counter / instruction address
reg_a  in  8  reg_bank output a (R[r_a])
reg_b  in  8  reg_bank output b (R[r_b])
alu_result  in  8  ALU output
mem_rdata  in  8  data memory read data
mem_ready  in  1  data memory access complete
r_a  out  2  reg_bank read address A = IR[3:2]
r_b  out  2  reg_bank read address B = IR[1:0]
write_addr  out  2  reg_bank write address = IR[3:2]
write_enable  out  1  reg_bank write strobe
write_data  out  8  mem_rdata for LD, else alu_result
alu_op  out  4  ALU operation = IR[7:4]; 4'b1001 (ADD) for ADDI
alu_b_imm  out  1  1: ALU operand B = imm; 0: reg_b
imm  out  8  {6'b0, IR[1:0]}
mem_addr  out  8  = reg_b
mem_wdata  out  8  = reg_a
mem_read  out  1  load strobe
mem_write  out  1  store strobe
halted  out  1  core stopped

Behaviour:
- Reset (async, rst_n=0):
  - state=FETCH, pc=RESET_PC, IR=8'h00.
  - write_enable, mem_read, mem_write, halted = 0 immediately, mid-instruction included; no partial write completes.
- Registered state: state, pc, IR. All other outputs are combinational from state and IR.
- States:
  - FETCH: IR<=instr at clock edge; ->DECODE.
  - DECODE: r_a/r_b valid so reg_bank outputs settle; ->EXECUTE; no strobes.
  - EXECUTE: strobes per opcode; pc updated on exit; ->FETCH, or ->HALT for opcode 1111.
  - HALT: terminal until reset; halted=1; pc frozen; no strobes.
- Opcodes (IR[7:4]):
  - 0000 BRZR: pc<=reg_b if reg_a==0, else pc+1.
  - 0001 JI: pc<=pc+sext(IR[3:0]), range -8..+7. Offset 0 is a legal self-loop.
  - 0010 LD: mem_read=1; write_enable=1 in the cycle mem_ready=1, write_data=mem_rdata.
  - 0011 ST: mem_write=1 until mem_ready=1.
  - 0100 ADDI: alu_b_imm=1, alu_op=ADD, write_enable=1.
  - 0101 NOT, 0110 AND, 0111 OR, 1000 XOR, 1001 ADD, 1010 SUB, 1011 SLL, 1100 SRL: alu_op=opcode, write_enable=1.
  - 1101, 1110: NOP (no strobes, pc+1).
  - 1111: HALT.
- Latency:
  - 3 cycles per non-memory instruction.
  - LD/ST stay in EXECUTE while mem_ready=0; mem_read/mem_write held stable; pc and IR unchanged.
  - When mem_ready=1 is sampled, the access completes at that edge and pc advances.
  - mem_ready is ignored for non-memory ops.
- write_enable asserts only in EXECUTE, at most one cycle per instruction. reg_bank captures at the EXECUTE->FETCH edge.
- pc is 8-bit modular: 8'hFF+1=8'h00; JI wraps both directions.
- Reads of the register being written (e.g. ADD R1,R1) use the pre-write value; no hazards exist in a multicycle design.

Test Plan:
- Reset/fetch: rst_n low → pc=00, all strobes 0. Release with instr=0x95 (ADD R1,R1) → write_enable high only in cycle 3, write_addr=01, r_a=01, r_b=01, alu_op=1001; pc=01 after 3 cycles.
- ADDI: IR=0x4E (R3+=2) → alu_b_imm=1, imm=02, alu_op=1001, write_addr=11, one write_enable pulse.
- Load wait states: LD R0,[R2] (0x22), mem_ready low 2 cycles → mem_read high 3 cycles, write_enable only in final cycle with write_data=mem_rdata=0xA5; pc advances once.
- Store: ST (0x3B), reg_a=0x53, reg_b=0x10 → mem_write=1, mem_addr=10, mem_wdata=53, write_enable=0.
- Branch/jump:
  - BRZR with reg_a=0, reg_b=0x40 → pc=40.
  - BRZR with reg_a=1 → pc+1.
  - JI 0x18 (-8) at pc=03 → pc=FB.
  - JI +1 at pc=FF → pc=00.
- Halt and async reset: 0xF0 → halted=1, pc frozen for 10 cycles. Drop rst_n mid-EXECUTE of a LD → strobes drop without waiting for a clock edge; no register write occurs; restart from pc=00.

Source files
------------

// File: rtl/control_unit.sv
// rtl/control_unit.sv - multicycle fetch/decode/execute sequencer for the Redux-V 8-bit core
//
// Ports:
//   clk, rst_n                 clock (rising edge), asynchronous active-low reset
//   instr[7:0]                 instruction at address pc (combinational ROM)
//   pc[7:0]                    program counter / instruction address
//   reg_a[7:0], reg_b[7:0]     reg_bank read data for r_a / r_b
//   alu_result[7:0]            ALU output
//   mem_rdata[7:0], mem_ready  data memory read data / access complete
//   r_a, r_b, write_addr       reg_bank addresses (IR[3:2], IR[1:0], IR[3:2])
//   write_enable, write_data   reg_bank write strobe / data
//   alu_op, alu_b_imm, imm     ALU control and immediate operand
//   mem_addr, mem_wdata        data memory address (reg_b) / store data (reg_a)
//   mem_read, mem_write        load / store strobes
//   halted                     core stopped until reset
module control_unit #(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] instr,
    output logic [7:0] pc,
    input  logic [7:0] reg_a,
    input  logic [7:0] reg_b,
    input  logic [7:0] alu_result,
    input  logic [7:0] mem_rdata,
    input  logic       mem_ready,
    output logic [1:0] r_a,
    output logic [1:0] r_b,
    output logic [1:0] write_addr,
    output logic       write_enable,
    output logic [7:0] write_data,
    output logic [3:0] alu_op,
    output logic       alu_b_imm,
    output logic [7:0] imm,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdata,
    output logic       mem_read,
    output logic       mem_write,
    output logic       halted
);

    typedef enum logic [1:0] {
        S_FETCH   = 2'd0,
        S_DECODE  = 2'd1,
        S_EXECUTE = 2'd2,
        S_HALT    = 2'd3
    } state_t;

    localparam logic [3:0] OP_BRZR = 4'b0000;
    localparam logic [3:0] OP_JI   = 4'b0001;
    localparam logic [3:0] OP_LD   = 4'b0010;
    localparam logic [3:0] OP_ST   = 4'b0011;
    localparam logic [3:0] OP_ADDI = 4'b0100;
    localparam logic [3:0] OP_NOT  = 4'b0101;
    localparam logic [3:0] OP_ADD  = 4'b1001;
    localparam logic [3:0] OP_SRL  = 4'b1100;
    localparam logic [3:0] OP_HALT = 4'b1111;

    state_t     state_q, state_d;
    logic [7:0] pc_q, pc_d;
    logic [7:0] ir_q, ir_d;

    logic [3:0] opcode;
    logic       in_exec;
    logic       is_mem;
    logic       is_alu_wr;
    logic [7:0] pc_inc;
    logic [7:0] ji_offset;

    assign opcode    = ir_q[7:4];
    assign in_exec   = (state_q == S_EXECUTE);
    assign is_mem    = (opcode == OP_LD) || (opcode == OP_ST);
    assign is_alu_wr = (opcode == OP_ADDI) || ((opcode >= OP_NOT) && (opcode <= OP_SRL));
    assign pc_inc    = pc_q + 8'd1;
    // 4-bit signed offset; 8-bit add wraps naturally in both directions
    assign ji_offset = {{4{ir_q[3]}}, ir_q[3:0]};

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        case (state_q)
            S_FETCH: begin
                ir_d    = instr;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                state_d = S_EXECUTE;
            end
            S_EXECUTE: begin
                // Memory ops hold here, with pc and IR frozen, until the access completes
                if (!(is_mem && !mem_ready)) begin
                    state_d = (opcode == OP_HALT) ? S_HALT : S_FETCH;
                    case (opcode)
                        OP_BRZR: pc_d = (reg_a == 8'h00) ? reg_b : pc_inc;
                        OP_JI:   pc_d = pc_q + ji_offset;
                        default: pc_d = pc_inc;
                    endcase
                end
            end
            default: begin
                state_d = S_HALT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= 8'h00;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    // Outputs are decoded from state and IR so that an asynchronous reset
    // removes every strobe immediately, without waiting for a clock edge.
    assign pc           = pc_q;
    assign r_a          = ir_q[3:2];
    assign r_b          = ir_q[1:0];
    assign write_addr   = ir_q[3:2];
    assign alu_b_imm    = (opcode == OP_ADDI);
    assign alu_op       = (opcode == OP_ADDI) ? OP_ADD : opcode;
    assign imm          = {6'b0, ir_q[1:0]};
    assign mem_addr     = reg_b;
    assign mem_wdata    = reg_a;
    assign mem_read     = in_exec && (opcode == OP_LD);
    assign mem_write    = in_exec && (opcode == OP_ST);
    // Loads write only in the completing cycle, so at most one pulse per instruction
    assign write_enable = in_exec && (is_alu_wr || ((opcode == OP_LD) && mem_ready));
    assign write_data   = (opcode == OP_LD) ? mem_rdata : alu_result;
    assign halted       = (state_q == S_HALT);

endmodule
